// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: round-robin two-master front end for sdram_core, routing read acks back via an id FIFO
module sdram_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RD_OUT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_m0_addr,
    input  logic [DATA_WIDTH-1:0]   i_m0_write_data,
    input  logic [DATA_WIDTH/8-1:0] i_m0_wr,
    input  logic                    i_m0_rd,
    output logic                    o_m0_accept,
    output logic                    o_m0_ack,
    output logic [DATA_WIDTH-1:0]   o_m0_read_data,
    input  logic [ADDR_WIDTH-1:0]   i_m1_addr,
    input  logic [DATA_WIDTH-1:0]   i_m1_write_data,
    input  logic [DATA_WIDTH/8-1:0] i_m1_wr,
    input  logic                    i_m1_rd,
    output logic                    o_m1_accept,
    output logic                    o_m1_ack,
    output logic [DATA_WIDTH-1:0]   o_m1_read_data,
    output logic [ADDR_WIDTH-1:0]   o_core_addr,
    output logic [DATA_WIDTH-1:0]   o_core_write_data,
    output logic [DATA_WIDTH/8-1:0] o_core_wr,
    output logic                    o_core_rd,
    input  logic                    i_core_accept,
    input  logic                    i_core_ack,
    input  logic [DATA_WIDTH-1:0]   i_core_read_data,
    output logic                    o_ack_orphan
);
    localparam int PW = $clog2(MAX_RD_OUT);
    localparam int CW = PW + 1;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t r_state, w_next;
    logic r_rr, r_orphan;
    logic [MAX_RD_OUT-1:0] r_ids;
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic w_m0_wreq, w_m1_wreq, w_m0_rd, w_m1_rd, w_full, w_empty;
    logic w_e0, w_e1, w_g0, w_g1, w_take, w_push, w_pop, w_head;
    assign w_m0_wreq = |i_m0_wr;
    assign w_m1_wreq = |i_m1_wr;
    assign w_m0_rd   = i_m0_rd & ~w_m0_wreq;
    assign w_m1_rd   = i_m1_rd & ~w_m1_wreq;
    assign w_full    = r_cnt == CW'(MAX_RD_OUT);
    assign w_empty   = r_cnt == '0;
    assign w_e0      = w_m0_wreq | (w_m0_rd & ~w_full);
    assign w_e1      = w_m1_wreq | (w_m1_rd & ~w_full);
    // reset drops the grant and the return path in the same cycle
    assign w_g0      = (r_state == GRANT0) & ~rst;
    assign w_g1      = (r_state == GRANT1) & ~rst;
    assign w_take    = i_core_accept & (w_g0 | w_g1);
    assign w_push    = w_take & (w_g0 ? w_m0_rd : w_m1_rd);
    assign w_pop     = i_core_ack & ~w_empty & ~rst;
    assign w_head    = r_ids[r_rp];
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE)
            w_next = (w_e0 & w_e1) ? (r_rr ? GRANT1 : GRANT0) : w_e0 ? GRANT0 : w_e1 ? GRANT1 : IDLE;
        else if (i_core_accept)
            w_next = IDLE;
    end
    assign o_core_addr       = w_g0 ? i_m0_addr : w_g1 ? i_m1_addr : '0;
    assign o_core_write_data = w_g0 ? i_m0_write_data : w_g1 ? i_m1_write_data : '0;
    assign o_core_wr         = w_g0 ? i_m0_wr : w_g1 ? i_m1_wr : '0;
    assign o_core_rd         = (w_g0 & w_m0_rd) | (w_g1 & w_m1_rd);
    assign o_m0_accept       = w_g0 & i_core_accept;
    assign o_m1_accept       = w_g1 & i_core_accept;
    assign o_m0_ack          = w_pop & ~w_head;
    assign o_m1_ack          = w_pop & w_head;
    assign o_m0_read_data    = o_m0_ack ? i_core_read_data : '0;
    assign o_m1_read_data    = o_m1_ack ? i_core_read_data : '0;
    assign o_ack_orphan      = r_orphan;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr     <= 1'b0;
            r_orphan <= 1'b0;
            r_ids    <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) r_rr <= w_g0;
            if (w_push) begin
                r_ids[r_wp] <= w_g1;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (i_core_ack & w_empty) r_orphan <= 1'b1;
        end
    end
endmodule
